// File: rtl/rsa_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_core_arbiter
//  Description : Round-robin arbiter that shares one rsa_encrypt core among
//                NUM_REQ requesters. Latches operands at grant, rejects
//                out-of-range operands, sequences compute/done, aborts stuck
//                jobs after TIMEOUT_CYCLES and returns the ciphertext over a
//                per-requester valid/ready response port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsa_core_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_M,
    input  logic [NUM_REQ*WIDTH-1:0]     req_e,
    input  logic [NUM_REQ*WIDTH-1:0]     req_n,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [WIDTH-1:0]             rsp_C,
    output logic                         rsp_err,
    output logic                         core_compute,
    output logic [WIDTH-1:0]             core_M,
    output logic [WIDTH-1:0]             core_e,
    output logic [WIDTH-1:0]             core_n,
    input  logic [WIDTH-1:0]             core_C,
    input  logic                         core_done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0] owner_q,   owner_d;
    logic [WIDTH-1:0] m_q,       m_d;
    logic [WIDTH-1:0] e_q,       e_d;
    logic [WIDTH-1:0] n_q,       n_d;
    logic             compute_q, compute_d;
    logic [WIDTH-1:0] rsp_c_q,   rsp_c_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TMR_W-1:0] timer_q,   timer_d;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;

    logic [WIDTH-1:0] m_arr [NUM_REQ];
    logic [WIDTH-1:0] e_arr [NUM_REQ];
    logic [WIDTH-1:0] n_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign m_arr[gi] = req_M[gi*WIDTH +: WIDTH];
            assign e_arr[gi] = req_e[gi*WIDTH +: WIDTH];
            assign n_arr[gi] = req_n[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin pick: indices above the last grant first, then wrap to 0..rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (IDX_W'(i) > rr_ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (IDX_W'(i) <= rr_ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

    // Job sequencer: grant/latch, range check, run with timeout, respond, drain done
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        m_d       = m_q;
        e_d       = e_q;
        n_d       = n_q;
        compute_d = compute_q;
        rsp_c_d   = rsp_c_q;
        rsp_err_d = rsp_err_q;
        timer_d   = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    m_d       = m_arr[grant_idx];
                    e_d       = e_arr[grant_idx];
                    n_d       = n_arr[grant_idx];
                    owner_d   = grant_idx;
                    rr_ptr_d  = grant_idx;
                    rsp_c_d   = '0;
                    rsp_err_d = 1'b0;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Operands the core cannot handle are rejected without starting it
                if ((n_q < WIDTH'(2)) || (m_q >= n_q)) begin
                    rsp_err_d = 1'b1;
                    rsp_c_d   = '0;
                    state_d   = ST_RESP;
                end else begin
                    compute_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // done is tested first so a result arriving on the last cycle is kept
                if (core_done) begin
                    rsp_c_d   = core_C;
                    rsp_err_d = 1'b0;
                    compute_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (timer_q == TMR_LAST) begin
                    rsp_c_d   = '0;
                    rsp_err_d = 1'b1;
                    compute_d = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Wait for the core to drop done so the next job never sees it
                if (!core_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= PTR_INIT;
            owner_q   <= '0;
            m_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            compute_q <= 1'b0;
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            m_q       <= m_d;
            e_q       <= e_d;
            n_q       <= n_d;
            compute_q <= compute_d;
            rsp_c_q   <= rsp_c_d;
            rsp_err_q <= rsp_err_d;
            timer_q   <= timer_d;
        end
    end

    // Accept is offered only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (reset_n && (state_q == ST_IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Response valid goes only to the requester that owns the job
    always_comb begin
        rsp_valid = '0;
        if (state_q == ST_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign rsp_C        = rsp_c_q;
    assign rsp_err      = rsp_err_q;
    assign core_compute = compute_q;
    assign core_M       = m_q;
    assign core_e       = e_q;
    assign core_n       = n_q;
    assign busy         = (state_q != ST_IDLE);
    assign owner        = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsa_core_arbiter
//  Description : Self-checking bench for rsa_core_arbiter with a stub RSA core
//                and a transaction-level reference model (round-robin pick,
//                range rules, done/timeout outcome, cycle counts).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_core_arbiter;

    localparam int NR = 2;
    localparam int W  = 32;
    localparam int TO = 16;

    logic            clk;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_M;
    logic [NR*W-1:0] req_e;
    logic [NR*W-1:0] req_n;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ready;
    logic [W-1:0]    rsp_C;
    logic            rsp_err;
    logic            core_compute;
    logic [W-1:0]    core_M;
    logic [W-1:0]    core_e;
    logic [W-1:0]    core_n;
    logic [W-1:0]    core_C;
    logic            core_done;
    logic            busy;
    logic [0:0]      owner;

    int n_vec  = 0;
    int n_miss = 0;
    int last_g;
    int stub_lat;
    int stub_clr;
    logic [W-1:0] op_m [NR];
    logic [W-1:0] op_e [NR];
    logic [W-1:0] op_n [NR];

    rsa_core_arbiter #(
        .NUM_REQ        (NR),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_M        (req_M),
        .req_e        (req_e),
        .req_n        (req_n),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_C        (rsp_C),
        .rsp_err      (rsp_err),
        .core_compute (core_compute),
        .core_M       (core_M),
        .core_e       (core_e),
        .core_n       (core_n),
        .core_C       (core_C),
        .core_done    (core_done),
        .busy         (busy),
        .owner        (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time budget exceeded");
        $fatal(1, "watchdog");
    end

    // Modular exponentiation, square-and-multiply
    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] n);
        logic [63:0] r;
        logic [63:0] x;
        if (n == '0) return '0;
        r = 64'(1) % 64'(n);
        x = 64'(b) % 64'(n);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % 64'(n);
            x = (x * x) % 64'(n);
        end
        return r[W-1:0];
    endfunction

    // Next grant: first requester after the last one granted, wrapping around
    function automatic int rr_pick(input int last, input logic [NR-1:0] mask);
        int c;
        for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            if (mask[c]) return c;
        end
        return 0;
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    endtask

    task automatic bound_fail(input string tag);
        n_vec++;
        n_miss++;
        $display("FAIL %s: DUT event not seen within cycle budget", tag);
        finish_run();
    endtask

    task automatic chk_all_zero(input string pfx);
        chk_eq({pfx, "_req_ready"}, 64'(req_ready), 64'(0));
        chk_eq({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk_eq({pfx, "_rsp_C"},     64'(rsp_C), 64'(0));
        chk_eq({pfx, "_rsp_err"},   64'(rsp_err), 64'(0));
        chk_eq({pfx, "_compute"},   64'(core_compute), 64'(0));
        chk_eq({pfx, "_core_M"},    64'(core_M), 64'(0));
        chk_eq({pfx, "_core_e"},    64'(core_e), 64'(0));
        chk_eq({pfx, "_core_n"},    64'(core_n), 64'(0));
        chk_eq({pfx, "_busy"},      64'(busy), 64'(0));
        chk_eq({pfx, "_owner"},     64'(owner), 64'(0));
    endtask

    task automatic rand_ops(input int i, input bit allow_bad);
        int mode;
        mode = allow_bad ? $urandom_range(0, 7) : 7;
        op_e[i] = W'($urandom_range(1, 65537));
        if (mode == 0) begin
            op_n[i] = W'($urandom_range(0, 1));
            op_m[i] = W'($urandom_range(0, 3));
        end else begin
            op_n[i] = W'($urandom) | W'(2);
            if (mode == 1) op_m[i] = op_n[i] | W'($urandom);
            else           op_m[i] = W'($urandom) % op_n[i];
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            req_M[i*W +: W] = op_m[i];
            req_e[i*W +: W] = op_e[i];
            req_n[i*W +: W] = op_n[i];
        end
    endtask

    task automatic scramble_ops();
        for (int i = 0; i < NR; i++) begin
            req_M[i*W +: W] = W'($urandom);
            req_e[i*W +: W] = W'($urandom);
            req_n[i*W +: W] = W'($urandom);
        end
    endtask

    // Stub core: raises done after stub_lat compute cycles (0 = never),
    // holds it stub_clr cycles after compute drops. Acts 2 time units after
    // the rising edge so the DUT samples it cleanly at the next edge.
    initial begin
        int cnt;
        int clr_cnt;
        cnt = 0;
        clr_cnt = 0;
        core_done = 1'b0;
        core_C = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                core_done = 1'b0;
                cnt = 0;
            end else if (core_compute) begin
                cnt++;
                clr_cnt = 0;
                if (stub_lat != 0 && cnt >= stub_lat) begin
                    core_done = 1'b1;
                    core_C = modexp(core_M, core_e, core_n);
                end else if (!core_done) begin
                    core_C = W'($urandom);
                end
            end else begin
                cnt = 0;
                if (core_done) begin
                    if (clr_cnt >= stub_clr) core_done = 1'b0;
                    else clr_cnt++;
                end else begin
                    core_C = W'($urandom);
                end
            end
        end
    end

    // One complete job: request, grant, run, response with backpressure, drain
    task automatic run_job(input logic [NR-1:0] mask, input int lat, input int clr,
                           input int hold, output logic [W-1:0] obs_c);
        int g;
        int cyc;
        int ccnt;
        int exp_cmp;
        logic [W-1:0] em, ee, en, exp_c, held_c;
        logic exp_err;
        logic prev_done;
        logic [NR-1:0] oh;

        g  = rr_pick(last_g, mask);
        em = op_m[g];
        ee = op_e[g];
        en = op_n[g];
        if (en < W'(2) || em >= en) begin
            exp_err = 1'b1; exp_c = '0; exp_cmp = 0;
        end else if (lat != 0 && lat <= TO) begin
            exp_err = 1'b0; exp_c = modexp(em, ee, en); exp_cmp = lat;
        end else begin
            exp_err = 1'b1; exp_c = '0; exp_cmp = TO;
        end
        oh = '0;
        oh[g] = 1'b1;
        stub_lat = lat;
        stub_clr = clr;

        drive_ops();
        req_valid = mask;
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (req_ready == '0) bound_fail("grant_wait");
        chk_eq("grant", 64'(req_ready), 64'(oh));
        last_g = g;

        @(negedge clk);
        req_valid = '0;
        scramble_ops();
        chk_eq("owner", 64'(owner), 64'(g));
        chk_eq("busy_check", 64'(busy), 64'(1));
        chk_eq("core_M", 64'(core_M), 64'(em));
        chk_eq("core_e", 64'(core_e), 64'(ee));
        chk_eq("core_n", 64'(core_n), 64'(en));
        chk_eq("compute_in_check", 64'(core_compute), 64'(0));

        cyc = 1;
        ccnt = 0;
        while (rsp_valid == '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (core_compute) ccnt++;
        end
        if (rsp_valid == '0) bound_fail("rsp_wait");
        chk_eq("rsp_valid", 64'(rsp_valid), 64'(oh));
        chk_eq("rsp_C", 64'(rsp_C), 64'(exp_c));
        chk_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
        chk_eq("compute_cycles", 64'(ccnt), 64'(exp_cmp));
        chk_eq("grant_to_rsp", 64'(cyc), 64'(exp_cmp + 2));
        obs_c  = rsp_C;
        held_c = rsp_C;

        for (int j = 0; j < hold; j++) begin
            rsp_ready = ~oh;
            req_valid = '1;
            @(negedge clk);
            chk_eq("hold_rsp_valid", 64'(rsp_valid), 64'(oh));
            chk_eq("hold_rsp_C", 64'(rsp_C), 64'(held_c));
            chk_eq("hold_no_grant", 64'(req_ready), 64'(0));
        end
        rsp_ready = oh;
        req_valid = '0;
        @(negedge clk);
        rsp_ready = '0;
        chk_eq("rsp_dropped", 64'(rsp_valid), 64'(0));

        cyc = 0;
        prev_done = core_done;
        while (busy && cyc < 50) begin
            prev_done = core_done;
            @(negedge clk);
            cyc++;
        end
        if (busy) bound_fail("drain_wait");
        chk_eq("drain_done_low", 64'(prev_done), 64'(0));
    endtask

    initial begin
        logic [W-1:0] c;
        logic [NR-1:0] mask;
        int cyc;

        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_M     = '0;
        req_e     = '0;
        req_n     = '0;
        stub_lat  = 0;
        stub_clr  = 0;
        last_g    = NR - 1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Both requesting continuously: grants alternate starting at 0
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NR; i++) rand_ops(i, 1'b0);
            run_job('1, 3, 1, 0, c);
            chk_eq("rr_owner", 64'(owner), 64'(k % 2));
        end

        // Known vector
        op_m[0] = 32'd65; op_e[0] = 32'd37; op_n[0] = 32'd16781;
        run_job(2'b01, 5, 0, 0, c);
        chk_eq("known_C", 64'(c), 64'd16030);

        // Range errors: M >= n, then n < 2
        op_m[1] = 32'd20000; op_e[1] = 32'd37; op_n[1] = 32'd16781;
        run_job(2'b10, 5, 0, 0, c);
        op_m[1] = 32'd0; op_n[1] = 32'd1;
        run_job(2'b10, 5, 0, 0, c);

        // Timeout boundaries: never done, done on last cycle, one late, one early
        rand_ops(0, 1'b0);
        run_job(2'b01, 0, 0, 0, c);
        run_job(2'b01, TO, 2, 0, c);
        run_job(2'b01, TO + 1, 0, 0, c);
        run_job(2'b01, TO - 1, 1, 0, c);

        // Long backpressure with the other requester's ready asserted
        rand_ops(0, 1'b0);
        run_job(2'b01, 4, 2, 10, c);

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < NR; i++) rand_ops(i, 1'b1);
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            run_job(mask, $urandom_range(1, TO + 4), $urandom_range(0, 3),
                    $urandom_range(0, 3), c);
        end

        // Reset in the middle of a running job
        op_m[1] = 32'd100; op_e[1] = 32'd3; op_n[1] = 32'd1009;
        stub_lat = 12;
        stub_clr = 0;
        drive_ops();
        req_valid = 2'b10;
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (req_ready == '0) bound_fail("mid_grant_wait");
        chk_eq("mid_grant", 64'(req_ready), 64'(2'b10));
        @(negedge clk);
        req_valid = '0;
        cyc = 0;
        while (!core_compute && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!core_compute) bound_fail("mid_run_wait");
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        reset_n = 1'b1;
        last_g = NR - 1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NR; i++) rand_ops(i, 1'b0);
        run_job('1, 4, 1, 1, c);
        chk_eq("post_reset_owner", 64'(owner), 64'(0));

        finish_run();
    end

endmodule
`default_nettype wire
